// File: rtl/mole_judge.sv
// Whack-a-mole round controller: lights a random mole after a dark gap, then
// judges the player's press as hit, wrong press or timeout and keeps score.
module mole_judge #(
    parameter int GAP_CYCLES    = 50_000_000,
    parameter int WINDOW_CYCLES = 100_000_000,
    parameter int ROUNDS        = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] num,
    input  logic [3:0] btn,
    output logic [3:0] mole,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] score,
    output logic [3:0] round,
    output logic       game_over
);

    // state | meaning
    // IDLE  | waiting for the first start after reset
    // GAP   | all moles dark, timer counting down to the next round
    // SHOW  | one mole lit, waiting for a press or the window to expire
    // DONE  | game finished, score and round held until start

    typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

    localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] WIN_LOAD   = 32'(WINDOW_CYCLES - 1);
    localparam logic [3:0]  ROUND_LAST = 4'(ROUNDS);

    state_t      state;
    logic [31:0] timer;
    logic [1:0]  sel;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  btn_prev;
    logic [3:0]  press;
    logic [3:0]  round_next;
    logic        hit;
    logic        wrong;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 4'b0;
            sync2    <= 4'b0;
            btn_prev <= 4'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            btn_prev <= sync2;
        end
    end

    // A held button yields one press: only the synchronized rising edge counts.
    assign press      = sync2 & ~btn_prev;
    assign hit        = press[sel];
    assign wrong      = |(press & ~(4'b0001 << sel));
    assign round_next = round + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= 32'd0;
            sel        <= 2'd0;
            mole       <= 4'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            score      <= 8'd0;
            round      <= 4'd0;
            game_over  <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= GAP;
                        timer <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (timer == 32'd0) begin
                        sel   <= num;
                        mole  <= 4'b0001 << num;
                        timer <= WIN_LOAD;
                        state <= SHOW;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                SHOW: begin
                    if (hit || wrong || timer == 32'd0) begin
                        if (hit) begin
                            hit_pulse <= 1'b1;
                            if (score != 8'hFF) score <= score + 8'd1;
                        end else begin
                            miss_pulse <= 1'b1;
                        end
                        round <= round_next;
                        mole  <= 4'b0;
                        if (round_next == ROUND_LAST) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                        end else begin
                            state <= GAP;
                            timer <= GAP_LOAD;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                DONE: begin
                    if (start) begin
                        score     <= 8'd0;
                        round     <= 4'd0;
                        game_over <= 1'b0;
                        state     <= GAP;
                        timer     <= GAP_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
